// File: rtl/sata_tx_scheduler.sv
// SATA link-layer transmit scheduler.
// Muxes link primitives and frame dwords into one registered dword stream,
// substitutes HOLD when the frame source underruns, and inserts an ALIGN
// pair after every ALIGN_PERIOD non-ALIGN dwords.

`ifndef ALIGN_PRIM
`define ALIGN_PRIM 32'h7B4A_4ABC
`endif
`ifndef HOLD_PRIM
`define HOLD_PRIM 32'hD5D5_AA7C
`endif
`ifndef DWORD_IS_PRIM
`define DWORD_IS_PRIM 1'b1
`endif
`ifndef DWORD_IS_DATA
`define DWORD_IS_DATA 1'b0
`endif

module sata_tx_scheduler #(
  parameter int unsigned ALIGN_PERIOD = 254
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        align_ena,
  input  logic        p_sel,
  input  logic [31:0] p_prim,
  input  logic [31:0] f_data,
  input  logic        f_valid,
  output logic        f_ready,
  output logic [31:0] o_data,
  output logic        o_datak,
  input  logic        o_ready,
  output logic        o_align,
  output logic        align_pending
);

  localparam int unsigned CNT_W = $clog2(ALIGN_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_PERIOD - 1);

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    ALIGN1 = 2'd1,
    ALIGN2 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // A frame dword is taken only on an advancing PASS slot while data is selected.
  assign f_ready       = o_ready & p_sel & (state == PASS);
  assign align_pending = (state != PASS);

  // Slot scheduler: state, ALIGN spacing counter and the output stream registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ALIGN2;
      cnt     <= '0;
      o_data  <= `ALIGN_PRIM;
      o_datak <= `DWORD_IS_PRIM;
      o_align <= 1'b1;
    end else if (o_ready) begin
      case (state)
        ALIGN1: begin
          o_data  <= `ALIGN_PRIM;
          o_datak <= `DWORD_IS_PRIM;
          o_align <= 1'b1;
          state   <= ALIGN2;
        end
        ALIGN2: begin
          o_data  <= `ALIGN_PRIM;
          o_datak <= `DWORD_IS_PRIM;
          o_align <= 1'b1;
          cnt     <= '0;
          state   <= PASS;
        end
        default: begin
          o_align <= 1'b0;
          if (!p_sel) begin
            o_data  <= p_prim;
            o_datak <= `DWORD_IS_PRIM;
          end else if (f_valid) begin
            o_data  <= f_data;
            o_datak <= `DWORD_IS_DATA;
          end else begin
            o_data  <= `HOLD_PRIM;
            o_datak <= `DWORD_IS_PRIM;
          end
          // HOLD slots count toward the period just like any other dword.
          if (!align_ena) begin
            cnt   <= '0;
            state <= PASS;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ALIGN1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= PASS;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sata_tx_scheduler.sv
// Directed testbench for sata_tx_scheduler: three instances (periods 254, 4, 1)
// share one set of inputs; each scenario checks the instance it targets.

module tb_sata_tx_scheduler;

  localparam logic [31:0] K_ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] K_HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] K_SYNC  = 32'hB5B5_957C;
  localparam logic [32:0] E_A     = {1'b1, K_ALIGN};
  localparam logic [32:0] E_H     = {1'b1, K_HOLD};
  localparam logic [32:0] E_S     = {1'b1, K_SYNC};

  logic        clk = 1'b0;
  logic        reset, align_ena, p_sel, f_valid, o_ready;
  logic [31:0] p_prim, f_data;

  logic        f_ready_254, o_datak_254, o_align_254, pend_254;
  logic [31:0] o_data_254;
  logic        f_ready_4, o_datak_4, o_align_4, pend_4;
  logic [31:0] o_data_4;
  logic        f_ready_1, o_datak_1, o_align_1, pend_1;
  logic [31:0] o_data_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sata_tx_scheduler #(.ALIGN_PERIOD(254)) u_p254 (
    .clk(clk), .reset(reset), .align_ena(align_ena), .p_sel(p_sel), .p_prim(p_prim),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_254), .o_data(o_data_254),
    .o_datak(o_datak_254), .o_ready(o_ready), .o_align(o_align_254), .align_pending(pend_254)
  );

  sata_tx_scheduler #(.ALIGN_PERIOD(4)) u_p4 (
    .clk(clk), .reset(reset), .align_ena(align_ena), .p_sel(p_sel), .p_prim(p_prim),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_4), .o_data(o_data_4),
    .o_datak(o_datak_4), .o_ready(o_ready), .o_align(o_align_4), .align_pending(pend_4)
  );

  sata_tx_scheduler #(.ALIGN_PERIOD(1)) u_p1 (
    .clk(clk), .reset(reset), .align_ena(align_ena), .p_sel(p_sel), .p_prim(p_prim),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_1), .o_data(o_data_1),
    .o_datak(o_datak_1), .o_ready(o_ready), .o_align(o_align_1), .align_pending(pend_1)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Reset under backpressure: every instance must come up in the ALIGN pair.
  task automatic test_reset;
    reset = 1'b1; o_ready = 1'b0; align_ena = 1'b1; p_sel = 1'b1; f_valid = 1'b1;
    p_prim = K_SYNC; f_data = 32'h0;
    tick();
    reset = 1'b0; o_ready = 1'b1;
    #1;
    checks++;
    if ({o_datak_254, o_data_254} !== E_A || {o_datak_4, o_data_4} !== E_A || {o_datak_1, o_data_1} !== E_A) begin
      errors++;
      $display("FAIL reset_word got %h/%h/%h want %h", {o_datak_254, o_data_254},
               {o_datak_4, o_data_4}, {o_datak_1, o_data_1}, E_A);
    end
    checks++;
    if ({o_align_254, o_align_4, o_align_1} !== 3'b111) begin
      errors++;
      $display("FAIL reset_o_align got %b want 111", {o_align_254, o_align_4, o_align_1});
    end
    checks++;
    if ({pend_254, pend_4, pend_1} !== 3'b111) begin
      errors++;
      $display("FAIL reset_align_pending got %b want 111", {pend_254, pend_4, pend_1});
    end
    checks++;
    if ({f_ready_254, f_ready_4, f_ready_1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_f_ready got %b want 000", {f_ready_254, f_ready_4, f_ready_1});
    end
  endtask

  // Default period: ALIGN, ALIGN, 254x SYNC, repeated twice.
  task automatic test_period_254;
    logic [32:0] exp_w;
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b0; p_prim = K_SYNC;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 512; k++) begin
      exp_w = ((k % 256) < 2) ? E_A : E_S;
      #1;
      checks++;
      if ({o_datak_254, o_data_254} !== exp_w || o_align_254 !== ((k % 256) < 2)) begin
        errors++;
        $display("FAIL period254 slot %0d got %h align %b want %h align %b", k,
                 {o_datak_254, o_data_254}, o_align_254, exp_w, ((k % 256) < 2));
      end
      tick();
    end
  endtask

  // Continuous frame data, period 4: no dword skipped or repeated around ALIGN.
  task automatic test_frame_stream;
    logic [32:0] e [0:12];
    logic [31:0] nxt;
    e = '{E_A, E_A, 33'd0, 33'd1, 33'd2, 33'd3, E_A, E_A, 33'd4, 33'd5, 33'd6, 33'd7, E_A};
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b1; f_valid = 1'b1;
    nxt = 32'd0; f_data = nxt;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      f_valid = 1'b1; f_data = nxt;
      #1;
      checks++;
      if ({o_datak_4, o_data_4} !== e[k] || o_align_4 !== (e[k] == E_A)) begin
        errors++;
        $display("FAIL frame slot %0d got %h align %b want %h", k, {o_datak_4, o_data_4}, o_align_4, e[k]);
      end
      checks++;
      if (f_ready_4 !== (e[k+1] != E_A) || pend_4 !== (e[k+1] == E_A)) begin
        errors++;
        $display("FAIL frame_ready slot %0d got f_ready %b pending %b want %b %b", k,
                 f_ready_4, pend_4, (e[k+1] != E_A), (e[k+1] == E_A));
      end
      tick();
      if (!e[k+1][32]) nxt++;
    end
  endtask

  // Source underrun: HOLDs fill the gap and count toward the period.
  task automatic test_underrun;
    logic [32:0] e [0:12];
    logic [31:0] nxt;
    e = '{E_A, E_A, 33'd0, 33'd1, E_H, E_H, E_A, E_A, 33'd2, 33'd3, 33'd4, 33'd5, E_A};
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b1; f_valid = 1'b1;
    nxt = 32'd0; f_data = nxt;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      f_valid = (e[k+1] != E_H); f_data = nxt;
      #1;
      checks++;
      if ({o_datak_4, o_data_4} !== e[k]) begin
        errors++;
        $display("FAIL underrun slot %0d got %h want %h", k, {o_datak_4, o_data_4}, e[k]);
      end
      checks++;
      if (f_ready_4 !== (e[k+1] != E_A)) begin
        errors++;
        $display("FAIL underrun_f_ready slot %0d got %b want %b", k, f_ready_4, (e[k+1] != E_A));
      end
      tick();
      if (!e[k+1][32]) nxt++;
    end
  endtask

  // Random downstream stalls must not change the stream or lose frame dwords.
  task automatic test_backpressure;
    logic [32:0] e [0:12];
    logic [31:0] nxt;
    int k, cyc, stalls;
    e = '{E_A, E_A, 33'd0, 33'd1, 33'd2, 33'd3, E_A, E_A, 33'd4, 33'd5, 33'd6, 33'd7, E_A};
    reset = 1'b1; o_ready = 1'b0; align_ena = 1'b1; p_sel = 1'b1; f_valid = 1'b1;
    nxt = 32'd0; f_data = nxt;
    tick();
    reset = 1'b0;
    k = 0; cyc = 0; stalls = 0;
    while (k < 12 && cyc < 300) begin
      o_ready = 1'($urandom_range(0, 1));
      f_valid = 1'b1; f_data = nxt;
      #1;
      checks++;
      if ({o_datak_4, o_data_4} !== e[k]) begin
        errors++;
        $display("FAIL backpressure cyc %0d slot %0d got %h want %h", cyc, k, {o_datak_4, o_data_4}, e[k]);
      end
      checks++;
      if (f_ready_4 !== (o_ready && (e[k+1] != E_A))) begin
        errors++;
        $display("FAIL backpressure_f_ready cyc %0d got %b want %b", cyc, f_ready_4,
                 (o_ready && (e[k+1] != E_A)));
      end
      tick();
      if (o_ready) begin
        if (!e[k+1][32]) nxt++;
        k++;
      end else begin
        stalls++;
      end
      cyc++;
    end
    o_ready = 1'b1;
    #1;
    checks++;
    if (k != 12 || {o_datak_4, o_data_4} !== e[12]) begin
      errors++;
      $display("FAIL backpressure_end slots %0d got %h want 12 slots ending %h (stalls %0d)",
               k, {o_datak_4, o_data_4}, e[12], stalls);
    end
  endtask

  function automatic bit t5_is_align(int j);
    return (j == 0 || j == 1 || j == 26 || j == 27 || j == 32 || j == 33);
  endfunction

  // align_ena gating: disabled for 20 words, re-enabled, then dropped mid-pair.
  task automatic test_align_enable;
    logic [32:0] exp_w;
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b0; p_prim = K_SYNC;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      align_ena = !((j >= 1 && j <= 20) || j >= 31);
      exp_w = t5_is_align(j) ? E_A : E_S;
      #1;
      checks++;
      if ({o_datak_4, o_data_4} !== exp_w || o_align_4 !== t5_is_align(j)) begin
        errors++;
        $display("FAIL align_ena slot %0d got %h align %b want %h", j, {o_datak_4, o_data_4}, o_align_4, exp_w);
      end
      checks++;
      if (pend_4 !== t5_is_align(j + 1)) begin
        errors++;
        $display("FAIL align_ena_pending slot %0d got %b want %b", j, pend_4, t5_is_align(j + 1));
      end
      tick();
    end
  endtask

  // Reset during ALIGN1 and mid-frame under backpressure restarts with a full pair.
  task automatic test_reset_midway;
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b0; p_prim = K_SYNC; f_valid = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    #1;
    checks++;
    if (pend_4 !== 1'b1 || {o_datak_4, o_data_4} !== E_S) begin
      errors++;
      $display("FAIL midreset_in_align1 got pending %b word %h want 1 %h", pend_4, {o_datak_4, o_data_4}, E_S);
    end
    reset = 1'b1; p_sel = 1'b1; f_data = 32'hCAFE_0001;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== E_A || o_align_4 !== 1'b1 || f_ready_4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_a got %h align %b f_ready %b want %h 1 0", {o_datak_4, o_data_4}, o_align_4, f_ready_4, E_A);
    end
    tick();
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== E_A || f_ready_4 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_a2 got %h f_ready %b want %h 1", {o_datak_4, o_data_4}, f_ready_4, E_A);
    end
    tick();
    f_data = 32'hCAFE_0002;
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== {1'b0, 32'hCAFE_0001} || o_align_4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_d1 got %h align %b want 0cafe0001 0", {o_datak_4, o_data_4}, o_align_4);
    end
    tick();
    o_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== E_A || o_align_4 !== 1'b1 || f_ready_4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_b got %h align %b f_ready %b want %h 1 0", {o_datak_4, o_data_4}, o_align_4, f_ready_4, E_A);
    end
    o_ready = 1'b1; f_data = 32'hCAFE_0003;
    #1;
    checks++;
    if (f_ready_4 !== 1'b0 || pend_4 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_b_ready got f_ready %b pending %b want 0 1", f_ready_4, pend_4);
    end
    tick();
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== E_A || o_align_4 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_b2 got %h want %h", {o_datak_4, o_data_4}, E_A);
    end
    tick();
    #1;
    checks++;
    if ({o_datak_4, o_data_4} !== {1'b0, 32'hCAFE_0003}) begin
      errors++;
      $display("FAIL midreset_d3 got %h want 0cafe0003", {o_datak_4, o_data_4});
    end
  endtask

  // Period of one: word, ALIGN, ALIGN, repeating.
  task automatic test_period_one;
    logic [32:0] exp_w;
    reset = 1'b1; o_ready = 1'b1; align_ena = 1'b1; p_sel = 1'b0; p_prim = K_SYNC;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 9; j++) begin
      exp_w = ((j % 3) == 2) ? E_S : E_A;
      #1;
      checks++;
      if ({o_datak_1, o_data_1} !== exp_w || pend_1 !== (((j + 1) % 3) != 2)) begin
        errors++;
        $display("FAIL period1 slot %0d got %h pending %b want %h %b", j, {o_datak_1, o_data_1},
                 pend_1, exp_w, (((j + 1) % 3) != 2));
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; align_ena = 1'b1; p_sel = 1'b0; f_valid = 1'b0; o_ready = 1'b1;
    p_prim = K_SYNC; f_data = 32'h0;
    test_reset();
    test_period_254();
    test_frame_stream();
    test_underrun();
    test_backpressure();
    test_align_enable();
    test_reset_midway();
    test_period_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sata_tx_scheduler.md
Name: sata_tx_scheduler

Overview:
Link-layer transmit scheduler placed ahead of the CONT inserter (sata_cont_inserter) in the TX path. Each dword slot carries either a link-FSM primitive or a frame-data dword. Emits HOLD when the frame source underruns. Inserts a mandatory ALIGN pair after every ALIGN_PERIOD dwords, and owns the output stream registers.

Parameters:
ALIGN_PERIOD, 254, number of non-ALIGN dwords emitted between consecutive ALIGN pairs (>= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
align_ena  input  1  enables periodic ALIGN pair insertion
p_sel  input  1  slot source select: 0 = primitive, 1 = frame data
p_prim  input  32  primitive to send while p_sel=0 (always treated as a primitive)
f_data  input  32  frame data dword
f_valid  input  1  f_data valid
f_ready  output  1  frame dword accepted this cycle when f_valid & f_ready
o_data  output  32  output stream dword, to CONT inserter
o_datak  output  1  output is primitive (`DWORD_IS_PRIM) or data (`DWORD_IS_DATA)
o_ready  input  1  downstream accepts o_data this cycle
o_align  output  1  current o_data is an ALIGN
align_pending  output  1  the next one or more slots are reserved for ALIGN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All flops, including the counter, update only on posedge clk.
- Output stream: o_data, o_datak and o_align are registers that are always valid. They load a new word only on a clk edge where o_ready=1. When o_ready=0, all state holds and f_ready=0.
- Reset values:
  - o_data=`ALIGN_PRIM, o_datak=`DWORD_IS_PRIM, o_align=1.
  - state=ALIGN2, cnt=0.
  - Effect: every reset is followed by a full ALIGN pair.
- FSM states: PASS, ALIGN1, ALIGN2. Each transition below happens only on an o_ready=1 edge.
  - ALIGN1: load ALIGN, go to ALIGN2.
  - ALIGN2: load ALIGN, set cnt=0, go to PASS.
  - PASS: load the selected word and increment cnt. If align_ena=1 and cnt==ALIGN_PERIOD-1, go to ALIGN1 with cnt=0.
- PASS word selection:
  - p_sel=0: load p_prim, datak=PRIM.
  - p_sel=1, f_valid=1: load f_data, datak=DATA; the dword is consumed.
  - p_sel=1, f_valid=0: load `HOLD_PRIM, datak=PRIM. This counts as a slot for cnt.
- o_align=1 exactly when the loaded word came from ALIGN1/ALIGN2 or from reset. A p_prim equal to ALIGN does not set o_align.
- f_ready = o_ready & p_sel & (state==PASS). It is combinational and has no dependency on f_valid. f_data must not be dropped or duplicated across ALIGN insertion.
- align_pending = (state != PASS).
- Counter width is $clog2(ALIGN_PERIOD+1). No wrap except the explicit clear.
- align_ena=0 in PASS: no ALIGN entry, cnt cleared to 0. Deasserting during ALIGN1/ALIGN2 does not abort the pair.
- Latency: the selected source is visible on o_data one clk after the accepting edge.
- p_sel changes take effect at the next accepting edge. No per-slot glitching of f_ready beyond the combinational terms above.
- ALIGN_PERIOD=1: pattern is 1 word, ALIGN, ALIGN, repeating.
- reset asserted mid-pair, mid-frame or under backpressure: the reset values above are restored at the next edge regardless of o_ready.

Test Plan:
1. Reset, o_ready=1 constant, align_ena=1, p_sel=0, p_prim=SYNC, ALIGN_PERIOD=254 -> ALIGN, ALIGN, 254x SYNC, ALIGN, ALIGN, 254x SYNC. Period 256; o_align high only on ALIGN slots.
2. ALIGN_PERIOD=4, p_sel=1, f_valid=1, f_data=0,1,2,... -> o_data = ALIGN, ALIGN, 0,1,2,3, ALIGN, ALIGN, 4,5,6,7 with datak=DATA on data slots. f_ready=0 in the two cycles where align_pending=1; no value skipped or repeated.
3. ALIGN_PERIOD=4, frame mode, f_valid low for 2 cycles after dword 1 -> 0, 1, HOLD, HOLD, ALIGN, ALIGN, 2, ... (HOLDs count toward the period).
4. Random o_ready (about 50% duty) on scenario 2 -> output sequence identical to the o_ready=1 run. o_data stable while o_ready=0; f_ready=0 whenever o_ready=0.
5. align_ena=0 after the reset pair, 20 words -> no ALIGN. Reassert align_ena -> next ALIGN pair after exactly ALIGN_PERIOD words. Deassert during ALIGN1 -> the pair still completes.
6. reset pulse during ALIGN1, and again mid-frame with o_ready=0 -> next cycle o_data=ALIGN, o_datak=PRIM, o_align=1, f_ready=0. Then a full ALIGN pair precedes any traffic.
